// File: rtl/slot_mapper.sv
// slot_mapper: MSX primary/secondary slot decoder plus MSX2-style RAM mapper.
//
// Four primary slots, selected per 16 KB page by the PPI port A byte (pslot_i).
// Each slot flagged in EXPANDED has a secondary-slot register at FFFFh; reads
// of that location return the register inverted. I/O ports FCh-FFh load the
// four mapper registers. Together these form the internal RAM address
// {map[page], addr[13:0]}.
//
// Optional feature macro: SLOT_MAPPER_READBACK_EN. When it is defined, I/O
// reads of FCh-FFh return the mapper page numbers, with the upper bits filled
// with 1s. When it is undefined, the mapper ports are write-only.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   addr, din             CPU address and CPU write data
//   mreq_n .. rfsh_n      Z80 bus strobes
//   pslot_i               primary slot byte, 2 bits per page
//   dout, dout_en         read data for FFFFh / mapper ports, and its mux enable
//   sltsl_n               primary slot selects, active low
//   subslot               secondary slot of the selected slot (0 if not expanded)
//   ram_addr, ram_cs      internal RAM address and chip select
//   ram_we                internal RAM write enable
module slot_mapper #(
    parameter logic [3:0]  EXPANDED      = 4'b1000,
    parameter int unsigned RAM_PAGE_BITS = 6,
    parameter int unsigned RAM_SLOT      = 3,
    parameter int unsigned RAM_SUBSLOT   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               addr,
    input  logic [7:0]                din,
    input  logic                      mreq_n,
    input  logic                      iorq_n,
    input  logic                      rd_n,
    input  logic                      wr_n,
    input  logic                      m1_n,
    input  logic                      rfsh_n,
    input  logic [7:0]                pslot_i,
    output logic [7:0]                dout,
    output logic                      dout_en,
    output logic [3:0]                sltsl_n,
    output logic [1:0]                subslot,
    output logic [RAM_PAGE_BITS+13:0] ram_addr,
    output logic                      ram_cs,
    output logic                      ram_we
);

    localparam int unsigned PW = RAM_PAGE_BITS;

    logic [7:0]    sub_q [4];
    logic [PW-1:0] map_q [4];
    logic          ffff_wr_prev_q;
    logic          map_wr_prev_q;

    logic [1:0] page;
    logic [1:0] ps;
    logic [1:0] ps_top;
    logic       mem_act;
    logic       ffff_hit;
    logic       ffff_wr;
    logic       map_port;
    logic       map_wr;

    assign page    = addr[15:14];
    assign ps      = pslot_i[2*page +: 2];
    assign ps_top  = pslot_i[7:6];
    assign mem_act = ~mreq_n & rfsh_n;

    // FFFFh always sits in page 3, so the slot that owns it is pslot_i[7:6].
    assign ffff_hit = mem_act & (addr == 16'hFFFF) & EXPANDED[ps_top];
    assign ffff_wr  = ffff_hit & ~wr_n;
    assign map_port = (addr[7:2] == 6'b111111);
    assign map_wr   = ~iorq_n & m1_n & rfsh_n & ~wr_n & map_port;

    always_comb begin
        sltsl_n = 4'hF;
        if (mem_act) begin
            sltsl_n = ~(4'b0001 << ps);
        end
    end

    assign subslot  = EXPANDED[ps] ? sub_q[ps][2*page +: 2] : 2'd0;
    assign ram_addr = {map_q[page], addr[13:0]};

    // An expanded RAM slot also needs the matching sub-slot. The expander
    // register shadows RAM at FFFFh.
    assign ram_cs = mem_act & (ps == 2'(RAM_SLOT))
                  & (~EXPANDED[RAM_SLOT] | (subslot == 2'(RAM_SUBSLOT)))
                  & ~ffff_hit;
    assign ram_we = ram_cs & ~wr_n;

`ifdef SLOT_MAPPER_READBACK_EN
    logic       map_rd;
    logic [7:0] rb_data;

    assign map_rd = ~iorq_n & ~rd_n & m1_n & rfsh_n & map_port;

    always_comb begin
        rb_data         = 8'hFF;
        rb_data[PW-1:0] = map_q[addr[1:0]];
    end

    always_comb begin
        dout    = 8'hFF;
        dout_en = 1'b0;
        if (ffff_hit & ~rd_n) begin
            dout    = ~sub_q[ps_top];
            dout_en = 1'b1;
        end else if (map_rd) begin
            dout    = rb_data;
            dout_en = 1'b1;
        end
    end
`else
    always_comb begin
        dout    = 8'hFF;
        dout_en = 1'b0;
        if (ffff_hit & ~rd_n) begin
            dout    = ~sub_q[ps_top];
            dout_en = 1'b1;
        end
    end
`endif

    // Writes are taken on the rising edge of the qualifying condition. The edge
    // detectors reset to "active", so a strobe held through reset release is
    // not taken as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                sub_q[i] <= 8'h00;
                map_q[i] <= PW'(3 - i);
            end
            ffff_wr_prev_q <= 1'b1;
            map_wr_prev_q  <= 1'b1;
        end else begin
            ffff_wr_prev_q <= ffff_wr;
            map_wr_prev_q  <= map_wr;
            if (ffff_wr && !ffff_wr_prev_q) begin
                sub_q[ps_top] <= din;
            end
            if (map_wr && !map_wr_prev_q) begin
                map_q[addr[1:0]] <= din[PW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_slot_mapper.sv
// Directed bench for slot_mapper with the default parameters: EXPANDED=1000b,
// 6-bit mapper pages, and RAM in slot 3-0.
module tb_slot_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [7:0]  pslot_i;
    logic [7:0]  dout;
    logic        dout_en;
    logic [3:0]  sltsl_n;
    logic [1:0]  subslot;
    logic [19:0] ram_addr;
    logic        ram_cs;
    logic        ram_we;

    int n_cmp = 0;
    int n_err = 0;

    slot_mapper dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .din      (din),
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .m1_n     (m1_n),
        .rfsh_n   (rfsh_n),
        .pslot_i  (pslot_i),
        .dout     (dout),
        .dout_en  (dout_en),
        .sltsl_n  (sltsl_n),
        .subslot  (subslot),
        .ram_addr (ram_addr),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, away from the sampling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; din = d; mreq_n = 1'b0; wr_n = 1'b0;
        tick();
        idle();
        tick();
    endtask

    task automatic io_wr(input logic [7:0] p, input logic [7:0] d);
        addr = {8'h00, p}; din = d; iorq_n = 1'b0; wr_n = 1'b0;
        tick();
        idle();
        tick();
    endtask

    // Starts a memory read and leaves it open so that the outputs can be checked.
    task automatic mem_rd_open(input logic [15:0] a);
        addr = a; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        addr = 16'h0000; din = 8'h00; pslot_i = 8'hC0; reset = 1'b1;
        tick(3);

        // Reset state
        chk("rst_dout", dout, 8'hFF);
        chk("rst_dout_en", dout_en, 1'b0);
        chk("rst_ram_cs", ram_cs, 1'b0);
        chk("rst_sltsl", sltsl_n, 4'hF);
        reset = 1'b0;
        tick(2);

        // Mapper readback of FDh: map[1]=2, upper bits filled with 1s
        addr = 16'h00FD; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
`ifdef SLOT_MAPPER_READBACK_EN
        chk("rb_fd_dout", dout, 8'hC2);
        chk("rb_fd_en", dout_en, 1'b1);
`else
        chk("rb_fd_en", dout_en, 1'b0);
        chk("rb_fd_dout", dout, 8'hFF);
`endif
        idle(); tick();

        // Page 0 after reset maps to page 3: 3*16384 + 1234h
        pslot_i = 8'h00;
        mem_rd_open(16'h1234);
        chk("p0_ram_addr", ram_addr, 20'h0D234);
        chk("p0_sltsl", sltsl_n, 4'b1110);
        chk("p0_ram_cs", ram_cs, 1'b0);
        idle(); tick();

        // Sub-slot register reset value, read back inverted
        pslot_i = 8'hC0;
        mem_rd_open(16'hFFFF);
        chk("sub_rst_dout", dout, 8'hFF);
        chk("sub_rst_en", dout_en, 1'b1);
        idle(); tick();

        // Expander write and inverted readback
        mem_wr(16'hFFFF, 8'h5A);
        mem_rd_open(16'hFFFF);
        chk("ffff_dout", dout, 8'hA5);
        chk("ffff_en", dout_en, 1'b1);
        chk("ffff_ram_cs", ram_cs, 1'b0);
        idle(); tick();

        // 4000h with pslot C0h is in non-expanded slot 0
        mem_rd_open(16'h4000);
        chk("s0_sltsl", sltsl_n, 4'b1110);
        chk("s0_subslot", subslot, 2'd0);
        idle(); tick();

        // 4000h in slot 3 uses sub[3][3:2] = 2, which is not the RAM sub-slot
        pslot_i = 8'hFF;
        mem_rd_open(16'h4000);
        chk("s3_sltsl", sltsl_n, 4'b0111);
        chk("s3_subslot", subslot, 2'd2);
        chk("s3_ram_cs", ram_cs, 1'b0);
        idle(); tick();

        // Non-expanded FFFFh is plain memory: no dout_en
        pslot_i = 8'h00;
        mem_rd_open(16'hFFFF);
        chk("nx_ffff_en", dout_en, 1'b0);
        chk("nx_ffff_sltsl", sltsl_n, 4'b1110);
        idle(); tick();

        // Slot 3 sub 0 everywhere, mapper page 2 set to 3Fh
        pslot_i = 8'hFF;
        mem_wr(16'hFFFF, 8'h00);
        io_wr(8'hFE, 8'h3F);
        mem_rd_open(16'h8123);
        chk("map_ram_addr", ram_addr, 20'hFC123);
        chk("map_ram_cs", ram_cs, 1'b1);
        chk("map_ram_we_rd", ram_we, 1'b0);
        idle(); tick();
        addr = 16'h8123; mreq_n = 1'b0; wr_n = 1'b0;
        #1;
        chk("map_ram_we", ram_we, 1'b1);
        idle(); tick();
        io_wr(8'hFE, 8'hC5);
        mem_rd_open(16'h8123);
        chk("map_trunc_c5", ram_addr, 20'h14123);
        idle(); tick();
        io_wr(8'hFE, 8'hFF);
        mem_rd_open(16'h8123);
        chk("map_trunc_ff", ram_addr, 20'hFC123);
        idle(); tick();

        // wr_n held 10 clk on FFFFh, din changes at clk 2: only 11h is taken
        pslot_i = 8'hC0;
        addr = 16'hFFFF; din = 8'h11; mreq_n = 1'b0; wr_n = 1'b0;
        tick(2);
        din = 8'h22;
        tick(8);
        idle(); tick();
        mem_rd_open(16'hFFFF);
        chk("hold_dout", dout, 8'hEE);
        idle(); tick();

        // Refresh cycle on FFFFh with wr_n low: no select, no write
        addr = 16'hFFFF; din = 8'h99; mreq_n = 1'b0; rfsh_n = 1'b0; wr_n = 1'b0;
        #1;
        chk("rfsh_sltsl", sltsl_n, 4'hF);
        chk("rfsh_dout_en", dout_en, 1'b0);
        chk("rfsh_ram_cs", ram_cs, 1'b0);
        tick(3);
        wr_n = 1'b1;
        tick();
        idle(); tick();
        mem_rd_open(16'hFFFF);
        chk("rfsh_nowrite", dout, 8'hEE);
        idle(); tick();

        // Reset asserted during a write, strobe held across the release
        addr = 16'hFFFF; din = 8'h77; mreq_n = 1'b0; wr_n = 1'b0; reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        idle(); tick();
        mem_rd_open(16'hFFFF);
        chk("rst_hold_dout", dout, 8'hFF);
        idle(); tick();
        // Mapper page 2 is back to its reset value 1
        pslot_i = 8'hFF;
        mem_rd_open(16'h8000);
        chk("rst_map2", ram_addr, 20'h04000);
        chk("rst_map2_cs", ram_cs, 1'b1);
        idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
